// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-requester front end for an external combinational ALU.
// One operation is in flight at a time: IDLE (accept) -> EXEC (ALU evaluates
// the captured operands) -> RESP (hold response until the consumer takes it).
// Arbitration is round-robin, or requester 0 always wins when FIXED_PRIO=1.
// Optional feature macro: DIVZERO_GUARD_EN -- when defined, divide (op 3) and
// modulo (op 10) with y==0 complete with data 8'h00 and the error flag set.
module alu_req_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [3:0] req0_x,
    input  logic [3:0] req0_y,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [3:0] req1_x,
    input  logic [3:0] req1_y,
    output logic [7:0] alu_ui_in,
    output logic [7:0] alu_uio_in,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic [3:0] op_q;
    logic [3:0] x_q;
    logic [3:0] y_q;
    logic       id_q;
    logic       accept;
    logic       grant_id;
    logic [7:0] result_d;
    logic       err_d;

    // Pick a winner and raise exactly one ready while idle and out of reset
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO != 0) begin
                grant_id = 1'b0;
            end else begin
                grant_id = ~last_grant;
            end
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        accept     = (state == IDLE) && !rst && (req0_valid || req1_valid);
        req0_ready = accept && !grant_id;
        req1_ready = accept && grant_id;
    end

    // Decide what the response will carry; reserved opcodes override the ALU
    always_comb begin
        result_d = alu_result;
        err_d    = 1'b0;
        if (op_q >= 4'd13) begin
            result_d = 8'h00;
            err_d    = 1'b1;
        end
`ifdef DIVZERO_GUARD_EN
        else if (((op_q == 4'd3) || (op_q == 4'd10)) && (y_q == 4'd0)) begin
            result_d = 8'h00;
            err_d    = 1'b1;
        end
`endif
    end

    // Sequencer: capture on accept, latch ALU output after EXEC, wait for consumer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= 4'h0;
            x_q        <= 4'h0;
            y_q        <= 4'h0;
            id_q       <= 1'b0;
            rsp_data   <= 8'h00;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= grant_id ? req1_op : req0_op;
                        x_q        <= grant_id ? req1_x  : req0_x;
                        y_q        <= grant_id ? req1_y  : req0_y;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= result_d;
                    rsp_err  <= err_d;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign alu_ui_in  = {y_q, x_q};
    assign alu_uio_in = {4'h0, op_q};
    assign rsp_id     = id_q;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: a round-robin instance and a fixed-priority
// instance share the same request stimulus; each drives its own ALU model.
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_op, req0_x, req0_y;
    logic [3:0] req1_op, req1_x, req1_y;
    logic       rsp_ready;

    logic       rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_err, rr_busy;
    logic [7:0] rr_ui, rr_uio, rr_alu, rr_rsp_data;
    logic       fx_req0_ready, fx_req1_ready, fx_rsp_valid, fx_rsp_id, fx_rsp_err, fx_busy;
    logic [7:0] fx_ui, fx_uio, fx_alu, fx_rsp_data;

    int checkCount = 0;
    int failCount  = 0;
    logic fx_req1_seen;

    always #5 clk = ~clk;

    // Reference ALU: op0 add, op1 sub, op2 mul, op3 div, op10 mod, else scramble
    function automatic logic [7:0] aluModel(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
        case (op)
            4'd0:    return 8'(x) + 8'(y);
            4'd1:    return 8'(x) - 8'(y);
            4'd2:    return 8'(x) * 8'(y);
            4'd3:    return (y == 4'd0) ? 8'hEE : 8'(x / y);
            4'd10:   return (y == 4'd0) ? 8'hDD : 8'(x % y);
            default: return {x, y} ^ 8'hA5;
        endcase
    endfunction

    assign rr_alu = aluModel(rr_uio[3:0], rr_ui[3:0], rr_ui[7:4]);
    assign fx_alu = aluModel(fx_uio[3:0], fx_ui[3:0], fx_ui[7:4]);

    alu_req_arbiter #(.FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(rr_req0_ready),
        .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(rr_req1_ready),
        .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
        .alu_ui_in(rr_ui), .alu_uio_in(rr_uio), .alu_result(rr_alu),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id),
        .rsp_data(rr_rsp_data), .rsp_err(rr_rsp_err), .busy(rr_busy)
    );

    alu_req_arbiter #(.FIXED_PRIO(1)) u_fx (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fx_req0_ready),
        .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(fx_req1_ready),
        .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y),
        .alu_ui_in(fx_ui), .alu_uio_in(fx_uio), .alu_result(fx_alu),
        .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fx_rsp_id),
        .rsp_data(fx_rsp_data), .rsp_err(fx_rsp_err), .busy(fx_busy)
    );

    // Remember whether the fixed-priority instance ever granted requester 1
    always @(negedge clk) begin
        if (fx_req1_ready) fx_req1_seen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [3:0] op0, input logic [3:0] x0, input logic [3:0] y0,
                                 input logic v1, input logic [3:0] op1, input logic [3:0] x1, input logic [3:0] y1);
        req0_valid = v0; req0_op = op0; req0_x = x0; req0_y = y0;
        req1_valid = v1; req1_op = op1; req1_x = x1; req1_y = y1;
    endtask

    // One full operation starting in IDLE with requests already applied
    task automatic doTransaction(input string tag, input logic exp_id, input logic exp_fx_id,
                                 input logic [7:0] exp_data, input logic exp_err);
        #1;
        checkOutput({tag, ".rdy0"}, 16'(rr_req0_ready), 16'(!exp_id));
        checkOutput({tag, ".rdy1"}, 16'(rr_req1_ready), 16'(exp_id));
        checkOutput({tag, ".fx_rdy0"}, 16'(fx_req0_ready), 16'(!exp_fx_id));
        step();
        checkOutput({tag, ".exec_busy"}, 16'(rr_busy), 16'd1);
        checkOutput({tag, ".exec_vld"}, 16'(rr_rsp_valid), 16'd0);
        checkOutput({tag, ".exec_rdy"}, 16'({rr_req0_ready, rr_req1_ready}), 16'd0);
        step();
        checkOutput({tag, ".vld"}, 16'(rr_rsp_valid), 16'd1);
        checkOutput({tag, ".id"}, 16'(rr_rsp_id), 16'(exp_id));
        checkOutput({tag, ".data"}, 16'(rr_rsp_data), 16'(exp_data));
        checkOutput({tag, ".err"}, 16'(rr_rsp_err), 16'(exp_err));
        checkOutput({tag, ".fx_vld"}, 16'(fx_rsp_valid), 16'd1);
        checkOutput({tag, ".fx_id"}, 16'(fx_rsp_id), 16'(exp_fx_id));
        rsp_ready = 1'b1;
        #1;
        checkOutput({tag, ".resp_rdy"}, 16'({rr_req0_ready, rr_req1_ready}), 16'd0);
        step();
        rsp_ready = 1'b0;
        checkOutput({tag, ".done_vld"}, 16'(rr_rsp_valid), 16'd0);
        checkOutput({tag, ".done_busy"}, 16'(rr_busy), 16'd0);
    endtask

    initial begin
        logic [7:0] div_data;
        logic       div_err;
        rst = 1'b1;
        rsp_ready = 1'b0;
        fx_req1_seen = 1'b0;
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        step();
        step();
        checkOutput("rst.vld", 16'(rr_rsp_valid), 16'd0);
        checkOutput("rst.busy", 16'(rr_busy), 16'd0);
        checkOutput("rst.ui", 16'(rr_ui), 16'd0);
        checkOutput("rst.uio", 16'(rr_uio), 16'd0);
        checkOutput("rst.data", 16'({rr_rsp_id, rr_rsp_err, rr_rsp_data}), 16'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checkOutput("rst.rdy", 16'({rr_req0_ready, rr_req1_ready}), 16'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Single add from requester 0
        applyStimulus(1'b1, 4'd0, 4'd3, 4'd4, 1'b0, 4'd0, 4'd0, 4'd0);
        #1;
        checkOutput("add.rdy0", 16'(rr_req0_ready), 16'd1);
        step();
        req0_valid = 1'b0;
        checkOutput("add.ui", 16'(rr_ui), 16'h43);
        checkOutput("add.uio", 16'(rr_uio), 16'h00);
        step();
        checkOutput("add.vld", 16'(rr_rsp_valid), 16'd1);
        checkOutput("add.id", 16'(rr_rsp_id), 16'd0);
        checkOutput("add.data", 16'(rr_rsp_data), 16'h07);
        checkOutput("add.err", 16'(rr_rsp_err), 16'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("add.done", 16'(rr_rsp_valid), 16'd0);

        // Both requesters continuously valid after a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        fx_req1_seen = 1'b0;
        applyStimulus(1'b1, 4'd2, 4'd5, 4'd3, 1'b1, 4'd2, 4'd5, 4'd3);
        doTransaction("rr0", 1'b0, 1'b0, 8'h0F, 1'b0);
        doTransaction("rr1", 1'b1, 1'b0, 8'h0F, 1'b0);
        doTransaction("rr2", 1'b0, 1'b0, 8'h0F, 1'b0);
        doTransaction("rr3", 1'b1, 1'b0, 8'h0F, 1'b0);
        checkOutput("fx.req1_never", 16'(fx_req1_seen), 16'd0);
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        step();

        // Divide by zero
`ifdef DIVZERO_GUARD_EN
        div_data = 8'h00;
        div_err  = 1'b1;
`else
        div_data = 8'hEE;
        div_err  = 1'b0;
`endif
        applyStimulus(1'b1, 4'd3, 4'd9, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0);
        doTransaction("div0", 1'b0, 1'b0, div_data, div_err);
        req0_valid = 1'b0;

        // Reserved opcode
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd14, 4'd1, 4'd1);
        doTransaction("op14", 1'b1, 1'b1, 8'h00, 1'b1);
        req1_valid = 1'b0;

        // Consumer stalls for five cycles while requester 0 waits
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd1, 4'd9, 4'd2);
        #1;
        checkOutput("stall.rdy1", 16'(rr_req1_ready), 16'd1);
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall.vld", 16'(rr_rsp_valid), 16'd1);
            checkOutput("stall.data", 16'({rr_rsp_id, rr_rsp_err, rr_rsp_data}), 16'h207);
            checkOutput("stall.rdy", 16'({rr_req0_ready, rr_req1_ready}), 16'd0);
            step();
        end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("stall.done", 16'(rr_rsp_valid), 16'd0);

        // Reset arriving while EXEC is in progress
        applyStimulus(1'b1, 4'd0, 4'd1, 4'd1, 1'b0, 4'd0, 4'd0, 4'd0);
        #1;
        checkOutput("abort.rdy0", 16'(rr_req0_ready), 16'd1);
        step();
        req0_valid = 1'b0;
        checkOutput("abort.exec", 16'(rr_busy), 16'd1);
        rst = 1'b1;
        step();
        checkOutput("abort.busy", 16'(rr_busy), 16'd0);
        checkOutput("abort.vld", 16'(rr_rsp_valid), 16'd0);
        checkOutput("abort.data", 16'(rr_rsp_data), 16'd0);
        rst = 1'b0;
        step();
        step();
        checkOutput("abort.no_rsp", 16'({rr_rsp_valid, rr_busy}), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
